// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: result word format and column packing helper.
package sa_pkg;

    localparam int unsigned FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    // Bit offset of column j inside a packed row of w-bit words
    function automatic int unsigned col_slice(input int unsigned j, input int unsigned w = FP_W);
        return j * w;
    endfunction

endpackage

// File: rtl/drain_row_fifo.sv
// Row FIFO for the result drain: DEPTH entries, registered head, full/empty flags.
// Caller only asserts push when it is legal (not full, or full with a pop in the same cycle).
module drain_row_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             bypass;

    // Next pointer/count; bypass when the pushed row becomes the head immediately
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        bypass     = 1'b0;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        count_nxt = count + CW'(push) - CW'(pop);
        bypass    = push && (count == CW'(pop));
    end

    // Storage array, no reset needed since head_valid gates its use
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, flags and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            full       <= (count_nxt == CW'(DEPTH));
            empty      <= (count_nxt == '0);
            head_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                head_data <= bypass ? push_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Systolic result drain: deskews per-column results into whole rows, buffers them
// in a row FIFO and drains them over valid/ready. Rows arriving at a full FIFO are
// dropped (the array cannot stall) and flagged.
// Optional build macro DRAIN_STATS_EN adds saturating rows_out / rows_dropped counters.
module systolic_result_drain
    import sa_pkg::*;
#(
    parameter int unsigned COLS      = 4,
    parameter int unsigned DATA_W    = FP_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TILE_ROWS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COLS-1:0]        col_valid,
    input  logic [COLS*DATA_W-1:0] col_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   overflow,
    output logic                   skew_err
`ifdef DRAIN_STATS_EN
   ,output logic [15:0]            rows_out,
    output logic [15:0]            rows_dropped
`endif
);

    localparam int unsigned ROW_W = COLS * DATA_W;
    localparam int unsigned ENT_W = ROW_W + 1;
    localparam int unsigned TC_W  = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

    logic [COLS-1:0]  dly_v;
    logic [ROW_W-1:0] dly_d;
    logic [COLS-1:0]  aln_v;
    logic [ROW_W-1:0] aln_d;

    logic             row_full;
    logic             row_mixed;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             tile_last;
    logic [TC_W-1:0]  tile_cnt;

    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] head_data;

    // Per-column delay lines: column j waits COLS-1-j cycles so all columns meet
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int unsigned NST = COLS - 1 - j;
        if (NST == 0) begin : g_direct
            assign dly_v[j] = col_valid[j];
            assign dly_d[col_slice(j, DATA_W) +: DATA_W] = col_data[col_slice(j, DATA_W) +: DATA_W];
        end else begin : g_dly
            logic [NST-1:0]    v_sr;
            logic [DATA_W-1:0] d_sr [NST];

            // Shift valid and data of this column down its delay line
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_sr <= '0;
                    for (int k = 0; k < NST; k++) begin
                        d_sr[k] <= DATA_W'(FP_ZERO);
                    end
                end else begin
                    v_sr[0] <= col_valid[j];
                    d_sr[0] <= col_data[col_slice(j, DATA_W) +: DATA_W];
                    for (int k = 1; k < NST; k++) begin
                        v_sr[k] <= v_sr[k-1];
                        d_sr[k] <= d_sr[k-1];
                    end
                end
            end

            assign dly_v[j] = v_sr[NST-1];
            assign dly_d[col_slice(j, DATA_W) +: DATA_W] = d_sr[NST-1];
        end
    end

    // Common align register holding one realigned row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aln_v <= '0;
            aln_d <= '0;
        end else begin
            aln_v <= dly_v;
            aln_d <= dly_d;
        end
    end

    // Row classification and FIFO admission
    always_comb begin
        row_full  = &aln_v;
        row_mixed = (|aln_v) && !(&aln_v);
        pop       = out_ready && !fifo_empty;
        push_ok   = row_full && (!fifo_full || pop);
        drop      = row_full && fifo_full && !pop;
        tile_last = (tile_cnt == TC_W'(TILE_ROWS - 1));
    end

    // Tile row counter advances only on accepted rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt <= '0;
        end else if (push_ok) begin
            tile_cnt <= tile_last ? '0 : tile_cnt + TC_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (row_mixed) begin
                skew_err <= 1'b1;
            end
        end
    end

`ifdef DRAIN_STATS_EN
    // Saturating drain statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_out     <= 16'h0000;
            rows_dropped <= 16'h0000;
        end else begin
            if (pop && (rows_out != 16'hFFFF)) begin
                rows_out <= rows_out + 16'd1;
            end
            if (drop && (rows_dropped != 16'hFFFF)) begin
                rows_dropped <= rows_dropped + 16'd1;
            end
        end
    end
`endif

    drain_row_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_ok),
        .push_data  ({tile_last, aln_d}),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (out_valid),
        .head_data  (head_data)
    );

    assign out_data = head_data[ROW_W-1:0];
    assign out_last = head_data[ROW_W];

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain (COLS=4, DEPTH=4, TILE_ROWS=4).
module tb_systolic_result_drain;

    localparam int unsigned COLS  = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TR    = 4;
    localparam int unsigned ROW_W = COLS * DW;

    typedef struct packed {
        logic             last;
        logic [ROW_W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [COLS-1:0]  col_valid = '0;
    logic [ROW_W-1:0] col_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ROW_W-1:0] out_data;
    logic             out_last;
    logic             overflow;
    logic             skew_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    systolic_result_drain #(
        .COLS      (COLS),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .TILE_ROWS (TR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_valid (col_valid),
        .col_data  (col_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .skew_err  (skew_err)
    );

    function automatic logic [ROW_W-1:0] row_val(input int id);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int j = 0; j < COLS; j++) begin
            r[j*DW +: DW] = 32'h4120_0000 + 32'(id * 256) + 32'(j);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_row(input int id, input logic last);
        exp_t e;
        e.last = last;
        e.data = row_val(id);
        exp_q.push_back(e);
    endtask

    // Checks every accepted row against the scoreboard head
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: actual data=%h with nothing pending, required no row", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", out_data, e.data);
                    check("row_last", ROW_W'(out_last), ROW_W'(e.last));
                end
            end
        end
    endtask

    // Drive n back-to-back skewed rows; column j of row r is presented at cycle r+j
    task automatic send_rows(input int n, input int first_id, input int omit_row, input int omit_col);
        logic [ROW_W-1:0] v;
        int r;
        for (int c = 0; c < n + int'(COLS) - 1; c++) begin
            for (int j = 0; j < COLS; j++) begin
                r = c - j;
                if (r >= 0 && r < n && !(r == omit_row && j == omit_col)) begin
                    v = row_val(first_id + r);
                    col_valid[j] = 1'b1;
                    col_data[j*DW +: DW] = v[j*DW +: DW];
                end else begin
                    col_valid[j] = 1'b0;
                    col_data[j*DW +: DW] = '0;
                end
            end
            @(posedge clk); #1;
        end
        col_valid = '0;
        col_data  = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        col_valid = '0;
        out_ready = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        check({name, "_drained"}, ROW_W'(exp_q.size()), '0);
        cycles(3);
        check({name, "_idle"}, ROW_W'(out_valid), '0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        cycles(1);

        // 1: outputs held at 0 under reset even with valid columns
        for (int i = 0; i < 3; i++) begin
            col_valid = 4'hF;
            col_data  = {$urandom, $urandom, $urandom, $urandom};
            cycles(1);
            check("rst_valid", ROW_W'(out_valid), '0);
            check("rst_data", out_data, '0);
            check("rst_last", ROW_W'(out_last), '0);
            check("rst_flags", ROW_W'({overflow, skew_err}), '0);
        end
        col_valid = '0;
        col_data  = '0;
        rst       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check("post_rst_valid", ROW_W'(out_valid), '0);
        end

        // 2: single row, latency COLS
        out_ready = 1'b1;
        expect_row(0, 1'b0);
        send_rows(1, 0, -1, -1);
        check("lat_before", ROW_W'(out_valid), '0);
        cycles(1);
        check("lat_at", ROW_W'(out_valid), ROW_W'(1));
        check("single_data", out_data, {32'h4120_0003, 32'h4120_0002, 32'h4120_0001, 32'h4120_0000});
        cycles(1);
        check("single_one_cycle", ROW_W'(out_valid), '0);
        wait_drain("single", 20);

        // 3: two streaming tiles
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_row(10 + i, (i % 4) == 3);
        send_rows(8, 10, -1, -1);
        wait_drain("stream", 40);
        check("stream_flags", ROW_W'({overflow, skew_err}), '0);

        // 4: backpressure, rows 4-5 dropped
        do_reset();
        for (int i = 0; i < 4; i++) expect_row(20 + i, i == 3);
        send_rows(6, 20, -1, -1);
        cycles(2);
        check("bp_overflow", ROW_W'(overflow), ROW_W'(1));
        check("bp_valid", ROW_W'(out_valid), ROW_W'(1));
        check("bp_head", out_data, row_val(20));
        cycles(3);
        check("bp_hold", out_data, row_val(20));
        check("bp_hold_last", ROW_W'(out_last), '0);
        out_ready = 1'b1;
        wait_drain("bp", 40);
        check("bp_skew", ROW_W'(skew_err), '0);

        // 5: push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 5; i++) expect_row(30 + i, i == 3);
        fork
            send_rows(5, 30, -1, -1);
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        cycles(2);
        check("fullpop_overflow", ROW_W'(overflow), '0);
        check("fullpop_head", out_data, row_val(31));
        send_rows(1, 35, -1, -1);
        cycles(2);
        check("fullpop_still_full", ROW_W'(overflow), ROW_W'(1));
        out_ready = 1'b1;
        wait_drain("fullpop", 40);

        // 6: partial row, then reset in the middle of a stream
        do_reset();
        out_ready = 1'b1;
        send_rows(1, 40, 0, 2);
        cycles(2);
        check("skew_flag", ROW_W'(skew_err), ROW_W'(1));
        check("skew_no_row", ROW_W'(out_valid), '0);
        check("skew_no_ovf", ROW_W'(overflow), '0);
        out_ready = 1'b0;
        send_rows(5, 41, -1, -1);
        cycles(2);
        check("pre_rst_overflow", ROW_W'(overflow), ROW_W'(1));
        fork
            send_rows(3, 46, -1, -1);
            begin
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        cycles(1);
        check("midrst_valid", ROW_W'(out_valid), '0);
        check("midrst_flags", ROW_W'({overflow, skew_err}), '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check("after_midrst_valid", ROW_W'(out_valid), '0);
        end
        check("after_midrst_flags", ROW_W'({overflow, skew_err}), '0);
        out_ready = 1'b1;
        expect_row(50, 1'b0);
        send_rows(1, 50, -1, -1);
        wait_drain("after_rst", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
